modbus_rtu_frame_check: RTL



---
 rtl/modbus_rtu_frame_check.sv | 111 +++++++++++
 1 files changed

// File: rtl/modbus_rtu_frame_check.sv
// MODBUS RTU receive framer: splits the UART byte stream on line silence
// and checks each frame's CRC-16 residual, length and error status.
module modbus_rtu_frame_check #(
    parameter int GAP_CYCLES = 1750,
    parameter int MAXLEN     = 256,
    parameter int LWIDTH     = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_err,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_ok,
    output logic [LWIDTH-1:0] frame_len,
    output logic [15:0]       crc_out
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    localparam logic [GW-1:0]     GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [LWIDTH-1:0] LEN_MAX  = LWIDTH'(MAXLEN);
    localparam logic [LWIDTH-1:0] LEN_MIN  = LWIDTH'(4);

    // Reflected CRC-16 (poly 0xA001), one whole byte per call.
    function automatic logic [15:0] crc_fold(
        input logic [15:0] c,
        input logic [7:0]  d
    );
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    logic [1:0]        state;
    logic [GW-1:0]     gap;
    logic [LWIDTH-1:0] len;
    logic [15:0]       crc;
    logic              gap_hit;

    assign gap_hit = (gap == GAP_LAST);
    assign busy    = (state != IDLE);
    assign crc_out = crc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gap        <= '0;
            len        <= '0;
            crc        <= 16'hFFFF;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_len  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_err) begin
                        state <= DROP;
                        gap   <= '0;
                    end else if (rx_valid) begin
                        state <= RECV;
                        crc   <= crc_fold(crc, rx_data);
                        len   <= LWIDTH'(1);
                        gap   <= '0;
                    end
                end
                RECV, DROP: begin
                    if (rx_err) begin
                        state <= DROP;
                        gap   <= '0;
                    end else if (rx_valid) begin
                        // A byte always beats an expiring gap.
                        gap <= '0;
                        if (state == RECV) begin
                            if (len == LEN_MAX) begin
                                state <= DROP;
                            end else begin
                                crc <= crc_fold(crc, rx_data);
                                len <= len + 1'b1;
                            end
                        end
                    end else if (gap_hit) begin
                        frame_done <= 1'b1;
                        frame_len  <= len;
                        frame_ok   <= (state == RECV) && (crc == 16'h0000)
                                      && (len >= LEN_MIN);
                        crc        <= 16'hFFFF;
                        len        <= '0;
                        gap        <= '0;
                        state      <= IDLE;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
